md5_result_uart_tx: RTL

MD5_RESULT_UART_TX -- requirements
Module: md5_result_uart_tx

---
 rtl/md5_result_uart_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/md5_result_uart_tx.sv
// rtl/md5_result_uart_tx.sv - UART reporter for MD5 search results ("F:xxxxxxxx\r\n" / "D\r\n").
// Optional even parity bit per frame when MD5_RESULT_TX_PARITY_EN is defined.
module md5_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic        status_found,
  input  logic        status_done,
  input  logic [31:0] target,
  output logic        UART_TXD,
  output logic        tx_busy,
  output logic [7:0]  drop_count
);

`ifdef MD5_RESULT_TX_PARITY_EN
  localparam logic [3:0] FRAME_BITS = 4'd11;
`else
  localparam logic [3:0] FRAME_BITS = 4'd10;
`endif
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, NEXT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_found_q;
  logic        r_done_q;
  logic        r_armed;
  logic        r_found_pend;
  logic        r_done_pend;
  logic        r_msg_found;
  logic [31:0] r_target;
  logic [3:0]  r_byte_idx;
  logic [10:0] r_shift;
  logic [3:0]  r_bits_left;
  logic [15:0] r_baud;
  logic        r_busy;
  logic [7:0]  r_drop;

  logic        w_found_rise;
  logic        w_done_rise;
  logic        w_found_block;
  logic        w_found_take;
  logic        w_found_drop;
  logic        w_done_drop;
  logic        w_start;
  logic        w_baud_end;
  logic        w_frame_done;
  logic [3:0]  w_last_idx;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic [7:0]  w_byte;
  logic [10:0] w_frame;
  logic [8:0]  w_drop_sum;

  // r_armed suppresses edges on inputs that were already high when reset released
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_found_q <= 1'b0;
      r_done_q  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_found_q <= status_found;
      r_done_q  <= status_done;
      r_armed   <= 1'b1;
    end
  end

  assign w_found_rise  = r_armed & status_found & ~r_found_q;
  assign w_done_rise   = r_armed & status_done & ~r_done_q;
  assign w_found_block = r_found_pend | ((r_state != IDLE) & r_msg_found);
  assign w_found_take  = w_found_rise & ~w_found_block;
  assign w_found_drop  = w_found_rise & w_found_block;
  assign w_done_drop   = w_done_rise & r_done_pend;
  assign w_start       = (r_state == IDLE) & (r_found_pend | r_done_pend);
  assign w_baud_end    = (r_baud == BAUD_LAST);
  assign w_frame_done  = (r_state == SEND) & w_baud_end & (r_bits_left == 4'd1);
  assign w_last_idx    = r_msg_found ? 4'd11 : 4'd2;
  assign w_drop_sum    = {1'b0, r_drop} + {8'b0, w_found_drop} + {8'b0, w_done_drop};

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_found_pend <= 1'b0;
      r_done_pend  <= 1'b0;
      r_target     <= 32'h0;
      r_drop       <= 8'h0;
    end else begin
      if (w_found_take) begin
        r_found_pend <= 1'b1;
        r_target     <= target;
      end else if (w_start && r_found_pend) begin
        r_found_pend <= 1'b0;
      end
      if (w_done_rise && !r_done_pend) begin
        r_done_pend <= 1'b1;
      end else if (w_start && !r_found_pend) begin
        r_done_pend <= 1'b0;
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // Message byte for the current index; hex digits walk the target MSB nibble first
  always_comb begin
    w_nib  = 4'(r_target >> {4'd9 - r_byte_idx, 2'b00});
    w_hex  = (w_nib < 4'd10) ? (8'h30 + {4'b0, w_nib}) : (8'h37 + {4'b0, w_nib});
    w_byte = 8'h0A;
    if (r_msg_found) begin
      case (r_byte_idx)
        4'd0:    w_byte = 8'h46;
        4'd1:    w_byte = 8'h3A;
        4'd10:   w_byte = 8'h0D;
        4'd11:   w_byte = 8'h0A;
        default: w_byte = w_hex;
      endcase
    end else begin
      case (r_byte_idx)
        4'd0:    w_byte = 8'h44;
        4'd1:    w_byte = 8'h0D;
        default: w_byte = 8'h0A;
      endcase
    end
`ifdef MD5_RESULT_TX_PARITY_EN
    w_frame = {1'b1, ^w_byte, w_byte, 1'b0};
`else
    w_frame = {2'b11, w_byte, 1'b0};
`endif
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_found_pend || r_done_pend) w_state_nxt = LOAD;
      LOAD: w_state_nxt = SEND;
      SEND: if (w_frame_done) w_state_nxt = NEXT;
      NEXT: w_state_nxt = (r_byte_idx != w_last_idx) ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line is r_shift[0]; ones shift in behind the stop bit so the line rests high
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_msg_found <= 1'b0;
      r_byte_idx  <= 4'd0;
      r_shift     <= '1;
      r_bits_left <= 4'd0;
      r_baud      <= 16'd0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_byte_idx  <= 4'd0;
            r_msg_found <= r_found_pend;
          end
        end
        LOAD: begin
          r_shift     <= w_frame;
          r_bits_left <= FRAME_BITS;
          r_baud      <= 16'd0;
        end
        SEND: begin
          if (w_baud_end) begin
            r_baud      <= 16'd0;
            r_shift     <= {1'b1, r_shift[10:1]};
            r_bits_left <= r_bits_left - 4'd1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        NEXT: begin
          if (r_byte_idx != w_last_idx) r_byte_idx <= r_byte_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign UART_TXD   = r_shift[0];
  assign tx_busy    = r_busy;
  assign drop_count = r_drop;

endmodule
